// File: rtl/rob_commit_unit_if.sv
// Bundle between the core pipeline and the reorder buffer: allocation from rename,
// completion broadcasts from the CDB, flush, and the in-order commit bundle.
interface rob_commit_unit_if #(
    parameter int unsigned ROB_DEPTH          = 16,
    parameter int unsigned MAX_NUM_OF_COMMITS = 4,
    parameter int unsigned PHY_REG_W          = 7,
    parameter int unsigned NUM_CDB            = 2,
    parameter int unsigned TAG_W              = $clog2(ROB_DEPTH)
);
    logic                                         alloc_valid;
    logic                                         alloc_has_dst;
    logic [PHY_REG_W-1:0]                         alloc_phy_dst;
    logic [TAG_W-1:0]                             alloc_tag;
    logic                                         rob_full;
    logic [NUM_CDB-1:0]                           cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]                cdb_tag;
    logic                                         flush;
    logic [MAX_NUM_OF_COMMITS-1:0]                commit_valid;
    logic [MAX_NUM_OF_COMMITS-1:0]                commit_with_write;
    logic [MAX_NUM_OF_COMMITS-1:0][PHY_REG_W-1:0] commited_wr_register;
    logic [MAX_NUM_OF_COMMITS-1:0][TAG_W-1:0]     commited_tags;
    logic [MAX_NUM_OF_COMMITS-1:0]                commited_tags_valid;

    // Pipeline side: drives requests, consumes tags and the commit bundle
    modport master (
        output alloc_valid, alloc_has_dst, alloc_phy_dst, cdb_valid, cdb_tag, flush,
        input  alloc_tag, rob_full, commit_valid, commit_with_write,
               commited_wr_register, commited_tags, commited_tags_valid
    );

    // Reorder buffer side
    modport slave (
        input  alloc_valid, alloc_has_dst, alloc_phy_dst, cdb_valid, cdb_tag, flush,
        output alloc_tag, rob_full, commit_valid, commit_with_write,
               commited_wr_register, commited_tags, commited_tags_valid
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement of up to MAX_NUM_OF_COMMITS entries per cycle.
// Entries are allocated at the tail, marked done by CDB broadcasts, and retired from
// the head; the commit bundle is registered and pulses for one cycle.
module rob_commit_unit #(
    parameter int unsigned ROB_DEPTH          = 16,
    parameter int unsigned MAX_NUM_OF_COMMITS = 4,
    parameter int unsigned PHY_REG_W          = 7,
    parameter int unsigned NUM_CDB            = 2,
    parameter int unsigned TAG_W              = $clog2(ROB_DEPTH)
) (
    input logic              clk,
    input logic              reset,
    rob_commit_unit_if.slave bus
);
    logic [ROB_DEPTH-1:0]                         r_busy;
    logic [ROB_DEPTH-1:0]                         r_done;
    logic [ROB_DEPTH-1:0]                         r_has_dst;
    logic [PHY_REG_W-1:0]                         r_phy_dst [ROB_DEPTH];
    logic [TAG_W-1:0]                             r_head;
    logic [TAG_W-1:0]                             r_tail;
    logic [TAG_W:0]                               r_count;
    logic [MAX_NUM_OF_COMMITS-1:0]                r_commit_valid;
    logic [MAX_NUM_OF_COMMITS-1:0]                r_commit_write;
    logic [MAX_NUM_OF_COMMITS-1:0][PHY_REG_W-1:0] r_commit_reg;
    logic [MAX_NUM_OF_COMMITS-1:0][TAG_W-1:0]     r_commit_tag;

    logic                                         w_full;
    logic                                         w_alloc_accept;
    logic [ROB_DEPTH-1:0]                         w_alloc_mask;
    logic [ROB_DEPTH-1:0]                         w_set_done;
    logic [ROB_DEPTH-1:0]                         w_retire;
    logic [TAG_W:0]                               w_k;
    logic [MAX_NUM_OF_COMMITS-1:0]                w_lane_valid;
    logic [MAX_NUM_OF_COMMITS-1:0]                w_lane_write;
    logic [MAX_NUM_OF_COMMITS-1:0][PHY_REG_W-1:0] w_lane_reg;
    logic [MAX_NUM_OF_COMMITS-1:0][TAG_W-1:0]     w_lane_tag;

    assign w_full         = (r_count == (TAG_W+1)'(ROB_DEPTH));
    // A full ROB refuses allocation even if retirement frees space this same cycle
    assign w_alloc_accept = bus.alloc_valid && !w_full && !bus.flush;

    // One-hot mask of the entry being allocated this cycle
    always_comb begin
        w_alloc_mask = '0;
        if (w_alloc_accept) begin
            w_alloc_mask[r_tail] = 1'b1;
        end
    end

    // CDB completions only land on entries that are already busy
    always_comb begin
        w_set_done = '0;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (bus.cdb_valid[i] && r_busy[bus.cdb_tag[i]]) begin
                w_set_done[bus.cdb_tag[i]] = 1'b1;
            end
        end
    end

    // Scan from head for consecutive done entries; the first not-done entry stops retirement
    always_comb begin
        logic             run;
        logic [TAG_W-1:0] idx;
        run          = 1'b1;
        idx          = '0;
        w_k          = '0;
        w_retire     = '0;
        w_lane_valid = '0;
        w_lane_write = '0;
        w_lane_reg   = '0;
        w_lane_tag   = '0;
        for (int j = 0; j < MAX_NUM_OF_COMMITS; j++) begin
            idx = r_head + TAG_W'(j);
            if (run && ((TAG_W+1)'(j) < r_count) && r_busy[idx] && r_done[idx]) begin
                w_retire[idx]   = 1'b1;
                w_lane_valid[j] = 1'b1;
                w_lane_write[j] = r_has_dst[idx];
                w_lane_reg[j]   = r_phy_dst[idx];
                w_lane_tag[j]   = idx;
                w_k             = w_k + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Entry status and pointers; flush and reset override every other update
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= (r_busy & ~w_retire) | w_alloc_mask;
            r_done  <= (r_done | w_set_done) & ~w_retire & ~w_alloc_mask;
            r_head  <= r_head + w_k[TAG_W-1:0];
            r_tail  <= r_tail + TAG_W'(w_alloc_accept);
            r_count <= r_count + (TAG_W+1)'(w_alloc_accept) - w_k;
        end
    end

    // Destination payload; only meaningful while the entry is busy, so no reset needed
    always_ff @(posedge clk) begin
        if (w_alloc_accept) begin
            r_has_dst[r_tail] <= bus.alloc_has_dst;
            r_phy_dst[r_tail] <= bus.alloc_phy_dst;
        end
    end

    // Registered commit bundle, one pulse per retirement
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_commit_valid <= '0;
            r_commit_write <= '0;
            r_commit_reg   <= '0;
            r_commit_tag   <= '0;
        end else begin
            r_commit_valid <= w_lane_valid;
            r_commit_write <= w_lane_write;
            r_commit_reg   <= w_lane_reg;
            r_commit_tag   <= w_lane_tag;
        end
    end

    assign bus.alloc_tag            = r_tail;
    assign bus.rob_full             = w_full;
    assign bus.commit_valid         = r_commit_valid;
    assign bus.commit_with_write    = r_commit_write;
    assign bus.commited_wr_register = r_commit_reg;
    assign bus.commited_tags        = r_commit_tag;
    assign bus.commited_tags_valid  = r_commit_valid;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: directed scenarios plus random traffic, all checked
// against a queue-based program-order model of the reorder buffer.
module tb_rob_commit_unit;
    localparam int DEPTH = 16;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rob_commit_unit_if bus_if ();

    rob_commit_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        int tag;
        bit has_dst;
        int dst;
        bit done;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic [3:0]  e_cv;
    logic [3:0]  e_cw;
    logic [27:0] e_regv;
    logic [15:0] e_tagv;
    bit          chk_en;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("alloc_tag", 64'(bus_if.alloc_tag), 64'(m_tail));
        check_eq("rob_full", 64'(bus_if.rob_full), 64'(q.size() == DEPTH));
        check_eq("commit_valid", 64'(bus_if.commit_valid), 64'(e_cv));
        check_eq("commit_with_write", 64'(bus_if.commit_with_write), 64'(e_cw));
        check_eq("commited_wr_register", 64'(bus_if.commited_wr_register), 64'(e_regv));
        check_eq("commited_tags", 64'(bus_if.commited_tags), 64'(e_tagv));
        check_eq("commited_tags_valid", 64'(bus_if.commited_tags_valid), 64'(e_cv));
    endtask

    // Program-order model: the queue holds exactly the busy entries, oldest first
    task automatic model_step(input bit av, input bit hd, input int dst, input bit [1:0] cv,
                              input int t0, input int t1, input bit fl, input bit rst);
        int         k;
        bit         was_full;
        logic [3:0] n_cv;
        logic [3:0] n_cw;
        logic [27:0] n_reg;
        logic [15:0] n_tag;
        ent_t       e;
        if (rst || fl) begin
            q.delete();
            m_tail = 0;
            e_cv = '0; e_cw = '0; e_regv = '0; e_tagv = '0;
            return;
        end
        was_full = (q.size() == DEPTH);
        k = 0; n_cv = '0; n_cw = '0; n_reg = '0; n_tag = '0;
        for (int j = 0; j < LANES && j < q.size(); j++) begin
            if (!q[j].done) break;
            n_cv[j]        = 1'b1;
            n_cw[j]        = q[j].has_dst;
            n_reg[j*7 +: 7] = 7'(q[j].dst);
            n_tag[j*4 +: 4] = 4'(q[j].tag);
            k++;
        end
        foreach (q[i]) begin
            if ((cv[0] && q[i].tag == t0) || (cv[1] && q[i].tag == t1)) q[i].done = 1'b1;
        end
        for (int j = 0; j < k; j++) void'(q.pop_front());
        if (av && !was_full) begin
            e.tag = m_tail; e.has_dst = hd; e.dst = dst; e.done = 1'b0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
        e_cv = n_cv; e_cw = n_cw; e_regv = n_reg; e_tagv = n_tag;
    endtask

    // One clock: check current outputs, drive inputs, advance model and DUT
    task automatic cycle(input bit av, input bit hd, input int dst, input bit [1:0] cv,
                         input int t0, input int t1, input bit fl, input bit rst);
        if (chk_en) check_outputs();
        bus_if.alloc_valid   = av;
        bus_if.alloc_has_dst = hd;
        bus_if.alloc_phy_dst = 7'(dst);
        bus_if.cdb_valid     = cv;
        bus_if.cdb_tag[0]    = 4'(t0);
        bus_if.cdb_tag[1]    = 4'(t1);
        bus_if.flush         = fl;
        reset                = rst;
        model_step(av, hd, dst, cv, t0, t1, fl, rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 2'b00, 0, 0, 0, 1);
    endtask

    task automatic alloc(input bit hd, input int dst);
        cycle(1, hd, dst, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic cdb1(input int t);
        cycle(0, 0, 0, 2'b01, t, 0, 0, 0);
    endtask

    task automatic cdb2(input int ta, input int tb);
        cycle(0, 0, 0, 2'b11, ta, tb, 0, 0);
    endtask

    function automatic int pick_tag();
        if (q.size() > 0 && $urandom_range(0, 3) != 0) return q[$urandom_range(0, q.size() - 1)].tag;
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        m_tail = 0; e_cv = '0; e_cw = '0; e_regv = '0; e_tagv = '0;
        bus_if.alloc_valid = 1'b0; bus_if.alloc_has_dst = 1'b0; bus_if.alloc_phy_dst = '0;
        bus_if.cdb_valid = '0; bus_if.cdb_tag = '0; bus_if.flush = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Reset then idle
        do_reset();
        chk_en = 1'b1;
        do_reset();
        idle(5);

        // In-order burst: all four done at once, so one four-lane commit
        alloc(1, 4); alloc(1, 5); alloc(0, 6); alloc(1, 7);
        cdb2(2, 3);
        cdb2(0, 1);
        idle(1);
        check_eq("burst_valid", 64'(bus_if.commit_valid), 64'h0f);
        check_eq("burst_write", 64'(bus_if.commit_with_write), 64'h0b);
        check_eq("burst_regs", 64'(bus_if.commited_wr_register), 64'({7'd7, 7'd6, 7'd5, 7'd4}));
        check_eq("burst_tags", 64'(bus_if.commited_tags), 64'h3210);
        idle(2);

        // Out-of-order completion: nothing retires until tag 0 is done
        do_reset();
        alloc(1, 10); alloc(1, 11); alloc(1, 12);
        cdb1(2); idle(1); cdb1(1); idle(2);
        cdb1(0); idle(1);
        check_eq("ooo_valid", 64'(bus_if.commit_valid), 64'h07);
        check_eq("ooo_tags", 64'(bus_if.commited_tags), 64'h0210);
        idle(2);

        // Full and refuse
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(1, 20 + i);
        check_eq("full_flag", 64'(bus_if.rob_full), 64'd1);
        check_eq("full_tag", 64'(bus_if.alloc_tag), 64'd0);
        alloc(1, 99);
        check_eq("refused_tag", 64'(bus_if.alloc_tag), 64'd0);
        cdb1(0);
        idle(1);
        check_eq("full_drop", 64'(bus_if.rob_full), 64'd0);
        idle(2);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 12; i++) alloc(i % 2, 30 + i);
        for (int i = 0; i < 12; i += 2) cdb2(i, i + 1);
        idle(4);
        for (int i = 0; i < 8; i++) alloc(1, 50 + i);
        cdb2(12, 13); cdb2(14, 15); cdb2(0, 1); cdb2(2, 3);
        idle(4);

        // Flush mid-flight, with a CDB in the flush cycle
        do_reset();
        for (int i = 0; i < 5; i++) alloc(1, 60 + i);
        cdb2(3, 4);
        cycle(0, 0, 0, 2'b01, 2, 0, 1, 0);
        idle(3);
        check_eq("flush_tag", 64'(bus_if.alloc_tag), 64'd0);
        check_eq("flush_full", 64'(bus_if.rob_full), 64'd0);
        alloc(1, 70);
        idle(2);

        // Random traffic; alternating phases let the ROB fill up and drain
        for (int n = 0; n < 3000; n++) begin
            bit       av;
            bit [1:0] cv;
            int       cdb_pct;
            cdb_pct = ((n / 250) % 2 == 1) ? 10 : 55;
            av = ($urandom_range(0, 9) < 6);
            cv[0] = ($urandom_range(0, 99) < cdb_pct);
            cv[1] = ($urandom_range(0, 99) < cdb_pct);
            cycle(av, 1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), cv,
                  pick_tag(), pick_tag(), ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 299) == 0));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
